// File: rtl/pi_switch_datapath.sv
// pi_switch_datapath: registers and route-decodes four packet buses, delays them to meet the
// arbiter's selects, steers them through a 4x4 crossbar and keeps deflection/conflict diagnostics.
module pi_switch_datapath #(
  parameter int p_sz       = 49,
  parameter int addr_width = 4,
  parameter int level      = 1,
  parameter int pos        = 0,
  parameter int arb_lat    = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [p_sz-1:0] l_bus_i,
  input  logic [p_sz-1:0] r_bus_i,
  input  logic [p_sz-1:0] ul_bus_i,
  input  logic [p_sz-1:0] ur_bus_i,
  output logic [1:0]      d_l,
  output logic [1:0]      d_r,
  output logic [1:0]      d_ul,
  output logic [1:0]      d_ur,
  input  logic [1:0]      sel_l,
  input  logic [1:0]      sel_r,
  input  logic [1:0]      sel_ul,
  input  logic [1:0]      sel_ur,
  input  logic            rand_gen,
  output logic            random,
  output logic [p_sz-1:0] l_bus_o,
  output logic [p_sz-1:0] r_bus_o,
  output logic [p_sz-1:0] ul_bus_o,
  output logic [p_sz-1:0] ur_bus_o,
  output logic [15:0]     deflect_cnt,
  output logic            conflict
);
  localparam logic [addr_width-1:0] pos_a = addr_width'(pos);
  localparam logic [1:0] exp_dir [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
  logic [p_sz-1:0] bus_i [4];
  logic [p_sz-1:0] in_b [4];
  logic [p_sz-1:0] a [4];
  logic [p_sz-1:0] src [4];
  logic [p_sz-1:0] bus_q [4];
  logic [p_sz-1:0] dl [arb_lat][4];
  logic [1:0] dd [arb_lat][4];
  logic [1:0] sel [4];
  logic [1:0] d [4];
  logic [1:0] ad [4];
  logic [1:0] idx [4];
  logic [2:0] hits [4];
  logic [2:0] dsum;
  logic [16:0] sum;
  logic cf;
  assign bus_i[0] = l_bus_i;
  assign bus_i[1] = r_bus_i;
  assign bus_i[2] = ul_bus_i;
  assign bus_i[3] = ur_bus_i;
  assign sel[0] = sel_l;
  assign sel[1] = sel_r;
  assign sel[2] = sel_ul;
  assign sel[3] = sel_ur;
  assign d_l = d[0];
  assign d_r = d[1];
  assign d_ul = d[2];
  assign d_ur = d[3];
  assign l_bus_o = bus_q[0];
  assign r_bus_o = bus_q[1];
  assign ul_bus_o = bus_q[2];
  assign ur_bus_o = bus_q[3];
  assign a = dl[arb_lat-1];
  assign ad = dd[arb_lat-1];

  function automatic logic [1:0] dec(input logic [p_sz-1:0] p);
    logic [addr_width-1:0] addr;
    addr = p[p_sz-2 -: addr_width];
    return !p[p_sz-1] ? 2'b00 : (addr >> level) != pos_a ? 2'b11 : addr[level-1] ? 2'b10 : 2'b01;
  endfunction

  always_comb
    for (int i = 0; i < 4; i++) d[i] = dec(in_b[i]);

  // select codes 01,10,11,00 name sources l,r,ul,ur, i.e. source index = sel - 1
  always_comb begin
    dsum = '0;
    cf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = sel[i] - 2'd1;
      src[i] = a[idx[i]];
      dsum = dsum + 3'(src[i][p_sz-1] && ad[idx[i]] != exp_dir[i]);
    end
    for (int j = 0; j < 4; j++) begin
      hits[j] = '0;
      for (int i = 0; i < 4; i++) hits[j] = hits[j] + 3'(idx[i] == 2'(j));
      cf = cf | (a[j][p_sz-1] && hits[j] != 3'd1);
    end
    sum = {1'b0, deflect_cnt} + 17'(dsum);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int j = 0; j < arb_lat; j++)
        for (int i = 0; i < 4; i++) begin
          dl[j][i] <= '0;
          dd[j][i] <= '0;
        end
      for (int i = 0; i < 4; i++) begin
        in_b[i] <= '0;
        bus_q[i] <= '0;
      end
      random <= 1'b0;
      deflect_cnt <= '0;
      conflict <= 1'b0;
    end else begin
      in_b <= bus_i;
      dl[0] <= in_b;
      dd[0] <= d;
      for (int j = 1; j < arb_lat; j++) begin
        dl[j] <= dl[j-1];
        dd[j] <= dd[j-1];
      end
      bus_q <= src;
      random <= random ^ rand_gen;
      deflect_cnt <= sum[16] ? 16'hFFFF : sum[15:0];
      conflict <= cf;
    end
endmodule

// File: tb/tb_pi_switch_datapath.sv
// tb_pi_switch_datapath: directed vectors with hand-computed expectations for pi_switch_datapath
// (level 1, pos 2, arb_lat 5).
module tb_pi_switch_datapath;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [48:0] l_bus_i, r_bus_i, ul_bus_i, ur_bus_i;
  logic [48:0] l_bus_o, r_bus_o, ul_bus_o, ur_bus_o;
  logic [1:0] d_l, d_r, d_ul, d_ur, sel_l, sel_r, sel_ul, sel_ur;
  logic rand_gen, random, conflict;
  logic [15:0] deflect_cnt;
  int nvec = 0;
  int nerr = 0;

  pi_switch_datapath #(.p_sz(49), .addr_width(4), .level(1), .pos(2), .arb_lat(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .l_bus_i(l_bus_i), .r_bus_i(r_bus_i), .ul_bus_i(ul_bus_i), .ur_bus_i(ur_bus_i),
    .d_l(d_l), .d_r(d_r), .d_ul(d_ul), .d_ur(d_ur),
    .sel_l(sel_l), .sel_r(sel_r), .sel_ul(sel_ul), .sel_ur(sel_ur),
    .rand_gen(rand_gen), .random(random),
    .l_bus_o(l_bus_o), .r_bus_o(r_bus_o), .ul_bus_o(ul_bus_o), .ur_bus_o(ur_bus_o),
    .deflect_cnt(deflect_cnt), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] pkt(input logic [3:0] addr, input logic [43:0] pl);
    return {1'b1, addr, pl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ident_sel();
    sel_l = 2'b01; sel_r = 2'b10; sel_ul = 2'b11; sel_ur = 2'b00;
  endtask

  task automatic void_in();
    l_bus_i = '0; r_bus_i = '0; ul_bus_i = '0; ur_bus_i = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    void_in();
    ident_sel();
    rand_gen = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic logic [3:0] vbits();
    return {l_bus_o[48], r_bus_o[48], ul_bus_o[48], ur_bus_o[48]};
  endfunction

  logic [48:0] p0, p1, p2, p3, pl;

  initial begin
    // reset with random valid traffic and toggling rand_gen
    reset_n = 1'b0;
    rand_gen = 1'b1;
    p0 = pkt(4'd4, 44'h0_0000_0000_A1);
    p1 = pkt(4'd5, 44'h0_0000_0000_B2);
    p2 = pkt(4'd9, 44'h0_0000_0000_C3);
    p3 = pkt(4'd12, 44'h0_0000_0000_D4);
    for (int n = 0; n < 4; n++) begin
      l_bus_i = {1'b1, 48'($urandom)}; r_bus_i = {1'b1, 48'($urandom)};
      ul_bus_i = {1'b1, 48'($urandom)}; ur_bus_i = {1'b1, 48'($urandom)};
      sel_l = 2'($urandom); sel_r = 2'($urandom); sel_ul = 2'($urandom); sel_ur = 2'($urandom);
      tick();
    end
    chk("rst_l_o", l_bus_o, 0);
    chk("rst_r_o", r_bus_o, 0);
    chk("rst_ul_o", ul_bus_o, 0);
    chk("rst_ur_o", ur_bus_o, 0);
    chk("rst_d", {d_l, d_r, d_ul, d_ur}, 0);
    chk("rst_random", random, 0);
    chk("rst_cnt", deflect_cnt, 0);
    chk("rst_conflict", conflict, 0);
    l_bus_i = p0; r_bus_i = p1; ul_bus_i = p2; ur_bus_i = p3;
    ident_sel();
    rand_gen = 1'b0;
    reset_n = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      chk($sformatf("rst_novalid_%0d", n), vbits(), 0);
    end
    tick();
    chk("rst_first_l", l_bus_o, p0);
    chk("rst_first_ur", ur_bus_o, p3);

    // decode: level 1, pos 2
    do_reset();
    l_bus_i = pkt(4'd4, 44'h1);
    tick();
    chk("dec_4", d_l, 2'b01);
    chk("dec_void_r", d_r, 2'b00);
    l_bus_i = pkt(4'd5, 44'h2);
    tick();
    chk("dec_5", d_l, 2'b10);
    l_bus_i = pkt(4'd9, 44'h3);
    tick();
    chk("dec_9", d_l, 2'b11);
    l_bus_i = '0;
    tick();
    chk("dec_void_l", d_l, 2'b00);

    // latency: RIGHT packet from l, routed to r at edge k+6
    do_reset();
    pl = pkt(4'd5, 44'h1_2345);
    l_bus_i = pl;
    tick();
    l_bus_i = '0;
    repeat (5) tick();
    chk("lat_early", r_bus_o, 0);
    sel_l = 2'b10; sel_r = 2'b01;
    tick();
    chk("lat_r_o", r_bus_o, pl);
    chk("lat_l_o", l_bus_o, 0);
    chk("lat_cnt", deflect_cnt, 0);
    chk("lat_conflict", conflict, 0);
    ident_sel();

    // three LEFT packets deflected to r
    do_reset();
    sel_l = 2'b10; sel_r = 2'b01;
    l_bus_i = pkt(4'd4, 44'h77);
    repeat (3) tick();
    l_bus_i = '0;
    repeat (8) tick();
    chk("defl_3", deflect_cnt, 16'd3);
    chk("defl_3_conf", conflict, 0);

    // saturation: four deflections per cycle
    do_reset();
    l_bus_i = pkt(4'd9, 44'h1); r_bus_i = pkt(4'd9, 44'h2);
    ul_bus_i = pkt(4'd4, 44'h3); ur_bus_i = pkt(4'd4, 44'h4);
    repeat (16383) tick();
    void_in();
    repeat (8) tick();
    chk("sat_fffc", deflect_cnt, 16'hFFFC);
    l_bus_i = pkt(4'd9, 44'h1); r_bus_i = pkt(4'd9, 44'h2);
    ul_bus_i = pkt(4'd4, 44'h3); ur_bus_i = pkt(4'd4, 44'h4);
    repeat (2) tick();
    void_in();
    repeat (8) tick();
    chk("sat_ffff", deflect_cnt, 16'hFFFF);
    l_bus_i = pkt(4'd9, 44'h1);
    tick();
    l_bus_i = '0;
    repeat (8) tick();
    chk("sat_hold", deflect_cnt, 16'hFFFF);

    // duplication conflict
    do_reset();
    sel_l = 2'b01; sel_r = 2'b01;
    pl = pkt(4'd4, 44'h55);
    l_bus_i = pl;
    tick();
    l_bus_i = '0;
    repeat (5) tick();
    chk("dup_pre", conflict, 0);
    tick();
    chk("dup_pulse", conflict, 1);
    chk("dup_l_o", l_bus_o, pl);
    chk("dup_r_o", r_bus_o, pl);
    tick();
    chk("dup_end", conflict, 0);

    // loss conflict: a_ul valid but unselected
    do_reset();
    sel_ul = 2'b10;
    ul_bus_i = pkt(4'd9, 44'h66);
    tick();
    ul_bus_i = '0;
    repeat (5) tick();
    chk("loss_pre", conflict, 0);
    tick();
    chk("loss_pulse", conflict, 1);
    tick();
    chk("loss_end", conflict, 0);

    // void sources with identical selects
    do_reset();
    sel_l = 2'b01; sel_r = 2'b01; sel_ul = 2'b01; sel_ur = 2'b01;
    for (int n = 0; n < 8; n++) begin
      tick();
      chk($sformatf("void_dup_%0d", n), conflict, 0);
    end

    // random toggling
    do_reset();
    chk("rnd_0", random, 0);
    rand_gen = 1'b1; tick(); chk("rnd_1", random, 1);
    rand_gen = 1'b1; tick(); chk("rnd_2", random, 0);
    rand_gen = 1'b0; tick(); chk("rnd_3", random, 0);
    rand_gen = 1'b1; tick(); chk("rnd_4", random, 1);
    rand_gen = 1'b0;

    // mid-operation reset drops in-flight packets
    do_reset();
    l_bus_i = pkt(4'd4, 44'h11); r_bus_i = pkt(4'd5, 44'h22); ul_bus_i = pkt(4'd9, 44'h33);
    tick();
    void_in();
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk($sformatf("mid_rst_%0d", n), {vbits(), conflict, deflect_cnt}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
